pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit that generates the per-bank enable (hold) and flush (bubble) controls consumed by the pipeline register banks.
- Combines load-use stalls, memory stalls, branch-redirect flushes and multi-cycle execute operations into one consistent stall/flush pattern every cycle.
- Sits beside the core datapath. Bank k is the register bank between stage k and stage k+1 (0=IF/ID, 1=ID/EX, 2=EX/MEM, 3..=later banks).

Parameters:
- NSTAGE, 5, number of pipeline stages; yields NSTAGE-1 register banks; must be at least 4.
- MCW, 6, width of the multi-cycle operation length and its counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- load_use  input  1  ID instruction depends on a load currently in EX
- redirect  input  1  branch mispredict resolved in EX; squash the younger banks
- mem_busy  input  1  memory not ready; freeze the whole pipeline while high
- mc_start  input  1  EX holds a multi-cycle op; held high by requester until mc_done
- mc_cycles  input  MCW  total cycles of the multi-cycle op, sampled with mc_start
- stage_en  output  NSTAGE-1  bit k=1: bank k captures; 0: bank k holds
- stage_flush  output  NSTAGE-1  bit k=1: bank k carries a bubble
- mc_done  output  1  final cycle of the multi-cycle op
- mc_active  output  1  FSM is in MC_BUSY

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is asynchronous, active-low.
  - While rst_n=0: state=RUN, counter=0, pend_flush=0, stage_en=all 0, stage_flush=all 1, mc_done=0, mc_active=0.
- Outputs are combinational from state plus current inputs. The next state registers on the rising edge of clk.
- RUN state, default pattern: stage_en=all 1, stage_flush=all 0.
- Priority in RUN, highest first: mem_busy, redirect or pend_flush, mc_start, load_use.
- mem_busy=1:
  - stage_en=all 0, stage_flush=all 0; go to MEM_WAIT.
  - If redirect=1 in the same cycle, set pend_flush.
- Redirect or pend_flush:
  - stage_en=all 1, stage_flush bits 0 and 1 = 1.
  - load_use and mc_start are ignored this cycle.
  - pend_flush clears.
- mc_start in RUN, with N = max(mc_cycles, 1):
  - If N=1: mc_done=1 this cycle, default pattern, stay in RUN.
  - Otherwise: load counter=N-1 and go to MC_BUSY. This cycle already uses the MC pattern: stage_en bits 0,1 = 0; bank 2 enabled with stage_flush bit 2 = 1; higher banks enabled.
- load_use: stage_en bit 0 = 0; bank 1 enabled with stage_flush bit 1 = 1; all other banks enabled. Single cycle, no state change.
- MEM_WAIT state:
  - Outputs: all en 0, all flush 0.
  - redirect=1 sets pend_flush.
  - Return to RUN in the cycle after mem_busy drops; the first RUN cycle applies pend_flush if it is set.
  - If the FSM entered MEM_WAIT from MC_BUSY, it returns to MC_BUSY instead.
- MC_BUSY state:
  - Counter decrements each cycle while mem_busy=0.
  - While counter>1: MC pattern.
  - When counter=1: mc_done=1, default pattern, go to RUN.
  - mem_busy=1 in MC_BUSY: freeze (all en 0), counter paused, go to MEM_WAIT and return to MC_BUSY afterwards.
- Don't-care inputs:
  - load_use is don't-care in MC_BUSY.
  - redirect in MC_BUSY is a protocol violation: ignored, flagged by assertion.
  - mc_start is ignored outside RUN.
- mc_active=1 in MC_BUSY, including its MEM_WAIT excursion.
- Counter wrap is impossible: N is at most 2^MCW-1.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - stall_cnt[31:0]: increments on each cycle with any stage_en bit 0 while rst_n=1.
  - flush_cnt[31:0]: increments on each cycle with stage_flush bit 0 = 1 caused by a redirect.
  - Both saturate at 32'hFFFFFFFF and reset asynchronously to 0.
- When undefined, neither the ports nor the counters exist.

Test Plan (all with NSTAGE=5):
- Reset: rst_n=0 gives stage_en=4'b0000, stage_flush=4'b1111. Releasing reset with all inputs 0 gives 4'b1111 / 4'b0000 on the next cycle.
- load_use=1 for one cycle gives stage_en=4'b1110, stage_flush=4'b0010. The next cycle returns to 4'b1111 / 4'b0000. load_use=1 together with redirect=1 gives 4'b1111 / 4'b0011.
- mem_busy=1 for 3 cycles, with redirect=1 in the 2nd, gives 3 cycles of 4'b0000 / 4'b0000. The first cycle after gives 4'b1111 / 4'b0011, and the cycle after that gives 4'b0000 flush.
- mc_start=1 with mc_cycles=4 gives 3 cycles of 4'b1100 / 4'b0100 with mc_active=1. The 4th cycle gives mc_done=1 and 4'b1111 / 4'b0000.
- mc_cycles=0 or 1 gives mc_done=1 in the start cycle with no stall. mc_cycles=4 with mem_busy=1 for 2 cycles in the 2nd cycle delays mc_done by exactly 2 cycles; stage_en=4'b0000 during the freeze.
- With PIPE_CTRL_PERF_CNT_EN defined: one load_use, one redirect and a 2-cycle mem_busy give stall_cnt=3, flush_cnt=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush control for pipeline register banks; optional perf counters via PIPE_CTRL_PERF_CNT_EN
module pipe_ctrl #(
  parameter int NSTAGE = 5,
  parameter int MCW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_use,
  input  logic              redirect,
  input  logic              mem_busy,
  input  logic              mc_start,
  input  logic [MCW-1:0]    mc_cycles,
  output logic [NSTAGE-2:0] stage_en,
  output logic [NSTAGE-2:0] stage_flush,
  output logic              mc_done,
  output logic              mc_active
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);
  localparam int NB = NSTAGE - 1;
  localparam logic [MCW-1:0] ONE = 1;
  localparam logic [NB-1:0] MC_EN = {{(NB-2){1'b1}}, 2'b00};
  localparam logic [NB-1:0] MC_FL = NB'(3'b100);
  localparam logic [NB-1:0] LU_EN = ~NB'(1'b1);
  localparam logic [NB-1:0] LU_FL = NB'(2'b10);
  localparam logic [NB-1:0] RD_FL = NB'(2'b11);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MC_BUSY} state_t;

  state_t state, state_nx, eff;
  logic [MCW-1:0] cnt, cnt_nx;
  logic pend, pend_nx, ret_mc, ret_mc_nx, done;
  logic [NB-1:0] en, fl;

  // MEM_WAIT with memory ready behaves as the state it returns to, so release takes effect the cycle mem_busy drops
  always_comb begin
    eff = (state == MEM_WAIT && !mem_busy) ? (ret_mc ? MC_BUSY : RUN) : state;
    state_nx = eff;
    cnt_nx = cnt;
    pend_nx = pend;
    ret_mc_nx = ret_mc;
    en = '1;
    fl = '0;
    done = 1'b0;
    if (eff == RUN) begin
      if (mem_busy) begin
        en = '0;
        state_nx = MEM_WAIT;
        ret_mc_nx = 1'b0;
        pend_nx = pend | redirect;
      end else if (redirect || pend) begin
        fl = RD_FL;
        pend_nx = 1'b0;
      end else if (mc_start) begin
        if (mc_cycles <= ONE) begin
          done = 1'b1;
        end else begin
          en = MC_EN;
          fl = MC_FL;
          cnt_nx = mc_cycles - ONE;
          state_nx = MC_BUSY;
        end
      end else if (load_use) begin
        en = LU_EN;
        fl = LU_FL;
      end
    end else if (eff == MC_BUSY) begin
      if (mem_busy) begin
        en = '0;
        state_nx = MEM_WAIT;
        ret_mc_nx = 1'b1;
      end else if (cnt <= ONE) begin
        done = 1'b1;
        cnt_nx = '0;
        state_nx = RUN;
      end else begin
        en = MC_EN;
        fl = MC_FL;
        cnt_nx = cnt - ONE;
      end
    end else begin
      en = '0;
      pend_nx = pend | redirect;
    end
  end

  // reset forces every bank to hold a bubble regardless of state
  always_comb begin
    stage_en = rst_n ? en : '0;
    stage_flush = rst_n ? fl : '1;
    mc_done = rst_n & done;
    mc_active = rst_n & (state == MC_BUSY || (state == MEM_WAIT && ret_mc));
  end

  // state, counter and pending-flush registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt <= '0;
      pend <= 1'b0;
      ret_mc <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pend <= pend_nx;
      ret_mc <= ret_mc_nx;
    end
  end

  a_no_redirect_in_mc: assert property (@(posedge clk) disable iff (!rst_n) state == MC_BUSY |-> !redirect);

`ifdef PIPE_CTRL_PERF_CNT_EN
  // saturating counts of stall cycles and redirect flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!(&stage_en) && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (stage_flush[0] && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl (NSTAGE=5, MCW=6)
module tb_pipe_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic load_use = 1'b0, redirect = 1'b0, mem_busy = 1'b0, mc_start = 1'b0;
  logic [5:0] mc_cycles = '0;
  logic [3:0] stage_en, stage_flush;
  logic mc_done, mc_active;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  int vectors = 0, errors = 0;

  typedef struct packed {
    logic lu, rd, mb, ms;
    logic [5:0] mcc;
    logic [3:0] en, fl;
    logic dn, act;
  } vec_t;
  typedef logic [9:0] obs_t;

  obs_t exp_q[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.NSTAGE(5), .MCW(6)) dut (
    .clk(clk), .rst_n(rst_n), .load_use(load_use), .redirect(redirect),
    .mem_busy(mem_busy), .mc_start(mc_start), .mc_cycles(mc_cycles),
    .stage_en(stage_en), .stage_flush(stage_flush), .mc_done(mc_done), .mc_active(mc_active)
`ifdef PIPE_CTRL_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic vec_t v(input logic lu, rd, mb, ms, input logic [5:0] mcc,
                             input logic [3:0] en, fl, input logic dn, act);
    return {lu, rd, mb, ms, mcc, en, fl, dn, act};
  endfunction

  // drive one cycle of inputs just after the edge, queue its expectation, then wait to mid-cycle
  task automatic drive(input vec_t r);
    @(posedge clk);
    #1;
    {load_use, redirect, mem_busy, mc_start, mc_cycles} = {r.lu, r.rd, r.mb, r.ms, r.mcc};
    exp_q.push_back({r.en, r.fl, r.dn, r.act});
    #4;
  endtask

  task automatic test_reset();
    obs_t got, e;
    #2;
    got = {stage_en, stage_flush, mc_done, mc_active};
    vectors++;
    if (got !== 10'b0000_1111_0_0) begin
      errors++;
      $display("FAIL reset_hold en/fl/done/act got %b expected %b", got, 10'b0000_1111_0_0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(v(0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0));
    got = {stage_en, stage_flush, mc_done, mc_active};
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_release en/fl/done/act got %b expected %b", got, e);
    end
  endtask

  task automatic test_load_use();
    vec_t t[6];
    obs_t got, e;
    t = '{v(1, 0, 0, 0, 0, 4'b1110, 4'b0010, 0, 0),
          v(0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0),
          v(1, 1, 0, 0, 0, 4'b1111, 4'b0011, 0, 0),
          v(0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0),
          v(1, 1, 0, 1, 6'd4, 4'b1111, 4'b0011, 0, 0),
          v(0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0)};
    foreach (t[i]) begin
      drive(t[i]);
      got = {stage_en, stage_flush, mc_done, mc_active};
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL load_use row %0d en/fl/done/act got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_mem_busy();
    vec_t t[5];
    obs_t got, e;
    t = '{v(0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0),
          v(0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0),
          v(0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0),
          v(0, 0, 0, 0, 0, 4'b1111, 4'b0011, 0, 0),
          v(0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0)};
    foreach (t[i]) begin
      drive(t[i]);
      got = {stage_en, stage_flush, mc_done, mc_active};
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL mem_busy row %0d en/fl/done/act got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_multicycle();
    vec_t t[5];
    obs_t got, e;
    t = '{v(0, 0, 0, 1, 6'd4, 4'b1100, 4'b0100, 0, 0),
          v(0, 0, 0, 1, 6'd4, 4'b1100, 4'b0100, 0, 1),
          v(1, 0, 0, 1, 6'd4, 4'b1100, 4'b0100, 0, 1),
          v(0, 0, 0, 1, 6'd4, 4'b1111, 4'b0000, 1, 1),
          v(0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0)};
    foreach (t[i]) begin
      drive(t[i]);
      got = {stage_en, stage_flush, mc_done, mc_active};
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL multicycle row %0d en/fl/done/act got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_short_ops();
    vec_t t[6];
    obs_t got, e;
    t = '{v(0, 0, 0, 1, 6'd0, 4'b1111, 4'b0000, 1, 0),
          v(0, 0, 0, 1, 6'd1, 4'b1111, 4'b0000, 1, 0),
          v(0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0),
          v(0, 0, 0, 1, 6'd2, 4'b1100, 4'b0100, 0, 0),
          v(0, 0, 0, 1, 6'd2, 4'b1111, 4'b0000, 1, 1),
          v(0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0)};
    foreach (t[i]) begin
      drive(t[i]);
      got = {stage_en, stage_flush, mc_done, mc_active};
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL short_ops row %0d en/fl/done/act got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_mc_freeze();
    vec_t t[7];
    obs_t got, e;
    t = '{v(0, 0, 0, 1, 6'd4, 4'b1100, 4'b0100, 0, 0),
          v(0, 0, 1, 1, 6'd4, 4'b0000, 4'b0000, 0, 1),
          v(0, 0, 1, 1, 6'd4, 4'b0000, 4'b0000, 0, 1),
          v(0, 0, 0, 1, 6'd4, 4'b1100, 4'b0100, 0, 1),
          v(0, 0, 0, 1, 6'd4, 4'b1100, 4'b0100, 0, 1),
          v(0, 0, 0, 1, 6'd4, 4'b1111, 4'b0000, 1, 1),
          v(0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0)};
    foreach (t[i]) begin
      drive(t[i]);
      got = {stage_en, stage_flush, mc_done, mc_active};
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL mc_freeze row %0d en/fl/done/act got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t got, e;
    drive(v(0, 0, 0, 1, 6'd9, 4'b1100, 4'b0100, 0, 0));
    got = {stage_en, stage_flush, mc_done, mc_active};
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      errors++;
      $display("FAIL async_reset_pre en/fl/done/act got %b expected %b", got, e);
    end
    @(posedge clk);
    #2;
    {rst_n, mc_start, mc_cycles} = '0;
    #1;
    got = {stage_en, stage_flush, mc_done, mc_active};
    vectors++;
    if (got !== 10'b0000_1111_0_0) begin
      errors++;
      $display("FAIL async_reset_mid en/fl/done/act got %b expected %b", got, 10'b0000_1111_0_0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(v(0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0));
    got = {stage_en, stage_flush, mc_done, mc_active};
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      errors++;
      $display("FAIL async_reset_post en/fl/done/act got %b expected %b", got, e);
    end
  endtask

`ifdef PIPE_CTRL_PERF_CNT_EN
  task automatic test_perf_cnt();
    vec_t t[5];
    obs_t got, e;
    t = '{v(1, 0, 0, 0, 0, 4'b1110, 4'b0010, 0, 0),
          v(0, 1, 0, 0, 0, 4'b1111, 4'b0011, 0, 0),
          v(0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0),
          v(0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0),
          v(0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0)};
    @(posedge clk);
    #1;
    {rst_n, load_use, redirect, mem_busy, mc_start, mc_cycles} = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vectors++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
    end
    foreach (t[i]) begin
      drive(t[i]);
      got = {stage_en, stage_flush, mc_done, mc_active};
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL perf row %0d en/fl/done/act got %b expected %b", i, got, e);
      end
    end
    vectors++;
    if (stall_cnt !== 32'd3 || flush_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_counts stall=%0d flush=%0d expected 3/1", stall_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_mem_busy();
    test_multicycle();
    test_short_ops();
    test_mc_freeze();
    test_async_reset();
`ifdef PIPE_CTRL_PERF_CNT_EN
    test_perf_cnt();
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
